// File: rtl/spi_command_router.sv
// spi_command_router
//   Assembles 8-byte SPI command frames, decodes the address to one of
//   NUM_CORES cores, issues WRITE/READ with a valid/ack handshake plus a
//   timeout, and serialises a 64-bit status/result response back out
//   through the SPI transmit byte.
// Ports
//   clk_i, rst_n_i         : clock, async active-low reset
//   spi_rx_valid_i/byte_i  : received byte strobe and data
//   frame_abort_i          : chip-select deasserted, restarts byte count
//   spi_tx_byte_o          : next byte to shift out (response byte[idx])
//   cmd_valid_o            : one-cycle command strobe
//   core_sel_o             : one-hot target core, held through WAIT
//   instruction_o/address_o/value_o : shared command buses (core-local addr)
//   result_i/result_valid_i: per-core result and acknowledge
//   stream_i               : per-core free-running stream values
module spi_command_router #(
    parameter int NUM_CORES = 2,
    parameter int CORE_SPAN = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   spi_rx_valid_i,
    input  logic [7:0]             spi_rx_byte_i,
    input  logic                   frame_abort_i,
    output logic [7:0]             spi_tx_byte_o,
    output logic                   cmd_valid_o,
    output logic [NUM_CORES-1:0]   core_sel_o,
    output logic [7:0]             instruction_o,
    output logic [23:0]            address_o,
    output logic [31:0]            value_o,
    input  logic [NUM_CORES*32-1:0] result_i,
    input  logic [NUM_CORES-1:0]   result_valid_i,
    input  logic [NUM_CORES*32-1:0] stream_i
);
    localparam int          KW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int          SW    = $clog2(CORE_SPAN);
    localparam logic [23:0] LMASK = 24'(CORE_SPAN - 1);
    localparam logic [31:0] LIMIT = 32'(NUM_CORES * CORE_SPAN);
    localparam logic [7:0]  ST_OK = 8'hA5, ST_ADDR = 8'hE1, ST_OP = 8'hE2,
                            ST_TMO = 8'hE3, ST_BUSY = 8'hE4;

    typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_WAIT} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [55:0]            frame_q, frame_d;      // bytes 0..6, byte 0 at top
    logic [63:0]            resp_q, resp_d;
    logic [7:0]             tx_q, tx_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [NUM_CORES-1:0]   core_sel_q, core_sel_d;
    logic [7:0]             instr_q, instr_d;
    logic [23:0]            addr_q, addr_d;
    logic [31:0]            value_q, value_d;
    logic [KW-1:0]          core_idx_q, core_idx_d;
    logic                   bad_addr_q, bad_addr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   drop_q, drop_d;        // a frame completed during WAIT

    logic                   rx_acc, last_byte, resp_load, drop_now, ack;
    logic [23:0]            full_addr;
    logic [KW-1:0]          k_dec;
    logic                   bad_dec;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        resp_d      = resp_q;
        tx_d        = tx_q;
        cmd_valid_d = 1'b0;
        core_sel_d  = core_sel_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        value_d     = value_q;
        core_idx_d  = core_idx_q;
        bad_addr_d  = bad_addr_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        resp_load   = 1'b0;

        // Abort wins over a coincident strobe; that byte is thrown away.
        rx_acc    = spi_rx_valid_i & ~frame_abort_i;
        last_byte = rx_acc && (idx_q == 3'd7);
        full_addr = frame_q[47:24];
        k_dec     = KW'(full_addr >> SW);
        bad_dec   = ({8'h00, full_addr} >= LIMIT);
        drop_now  = drop_q | last_byte;
        ack       = result_valid_i[core_idx_q];

        if (frame_abort_i)
            idx_d = 3'd0;
        else if (rx_acc)
            idx_d = idx_q + 3'd1;

        if (rx_acc && idx_q != 3'd7)
            frame_d[8*(6-int'(idx_q)) +: 8] = spi_rx_byte_i;

        case (state_q)
            S_COLLECT: begin
                if (last_byte) begin
                    instr_d    = frame_q[55:48];
                    addr_d     = full_addr & LMASK;
                    value_d    = {frame_q[23:0], spi_rx_byte_i};
                    core_idx_d = k_dec;
                    bad_addr_d = bad_dec;
                    if ((frame_q[55:48] == 8'h01 || frame_q[55:48] == 8'h02) && !bad_dec) begin
                        cmd_valid_d = 1'b1;
                        core_sel_d  = NUM_CORES'(1) << k_dec;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d     = 8'd0;
                state_d   = S_COLLECT;
                resp_load = 1'b1;
                // Opcode check precedes address check: a NOP never needs a core.
                if (instr_q > 8'h03)
                    resp_d = {ST_OP, 56'h0};
                else if (instr_q == 8'h00)
                    resp_d = {ST_OK, 56'h0};
                else if (bad_addr_q)
                    resp_d = {ST_ADDR, 56'h0};
                else if (instr_q == 8'h03)
                    resp_d = {ST_OK, 24'h0, stream_i[32*int'(core_idx_q) +: 32]};
                else begin
                    resp_load = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack || cnt_q == 8'(TIMEOUT - 1)) begin
                    resp_load  = 1'b1;
                    core_sel_d = '0;
                    drop_d     = 1'b0;
                    state_d    = S_COLLECT;
                    if (drop_now)
                        resp_d = {ST_BUSY, 56'h0};
                    else if (ack)
                        resp_d = {ST_OK, 24'h0, result_i[32*int'(core_idx_q) +: 32]};
                    else
                        resp_d = {ST_TMO, 56'h0};
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    drop_d = drop_now;
                end
            end
            default: state_d = S_COLLECT;
        endcase

        if (rx_acc || frame_abort_i || resp_load)
            tx_d = resp_d[8*(7-int'(idx_d)) +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_COLLECT;
            idx_q       <= '0;
            frame_q     <= '0;
            resp_q      <= '0;
            tx_q        <= '0;
            cmd_valid_q <= 1'b0;
            core_sel_q  <= '0;
            instr_q     <= '0;
            addr_q      <= '0;
            value_q     <= '0;
            core_idx_q  <= '0;
            bad_addr_q  <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            resp_q      <= resp_d;
            tx_q        <= tx_d;
            cmd_valid_q <= cmd_valid_d;
            core_sel_q  <= core_sel_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            core_idx_q  <= core_idx_d;
            bad_addr_q  <= bad_addr_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    assign spi_tx_byte_o = tx_q;
    assign cmd_valid_o   = cmd_valid_q;
    assign core_sel_o    = core_sel_q;
    assign instruction_o = instr_q;
    assign address_o     = addr_q;
    assign value_o       = value_q;
endmodule

// File: tb/tb_spi_command_router.sv
module tb_spi_command_router;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rx_valid, abort;
    logic [7:0]      rx_byte, tx;
    logic            cmd_valid;
    logic [NC-1:0]   core_sel, rv;
    logic [7:0]      instr;
    logic [23:0]     addr;
    logic [31:0]     value;
    logic [NC*32-1:0] result, stream;

    int checks = 0;
    int failures = 0;
    logic [7:0] txs [8];

    always #5 clk = ~clk;

    spi_command_router #(.NUM_CORES(NC), .CORE_SPAN(16), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .spi_rx_valid_i(rx_valid), .spi_rx_byte_i(rx_byte),
        .frame_abort_i(abort), .spi_tx_byte_o(tx),
        .cmd_valid_o(cmd_valid), .core_sel_o(core_sel),
        .instruction_o(instr), .address_o(addr), .value_o(value),
        .result_i(result), .result_valid_i(rv), .stream_i(stream)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at a negedge; returns at the negedge of cycle t+1 where t is
    // the byte-7 strobe cycle. txs[i] is the tx byte seen while byte i is sent.
    task automatic send_frame(input logic [63:0] f, input bit b2b);
        for (int i = 0; i < 8; i++) begin
            if (!b2b && i > 0) begin
                rx_valid = 1'b0;
                cyc(1);
            end
            txs[i]   = tx;
            rx_valid = 1'b1;
            rx_byte  = f[63-8*i -: 8];
            cyc(1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic chk_tx(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_b%0d", tag, i), {56'h0, txs[i]}, {56'h0, exp[63-8*i -: 8]});
    endtask

    initial begin
        rx_valid = 0; abort = 0; rx_byte = 0; rv = 0; result = '0; stream = '0;
        cyc(2);
        chk("rst_tx", tx, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_core_sel", core_sel, 0);
        chk("rst_buses", {instr, addr, value}, 0);
        rst_n = 1'b1;
        cyc(1);

        // WRITE core 1, local addr 2, ack at t+3
        result[63:32] = 32'h0BADF00D;
        send_frame({8'h01, 24'h000012, 32'hDEADBEEF}, 0);
        chk("wr_cmd_valid_t1", cmd_valid, 1);
        chk("wr_core_sel_t1", core_sel, 2'b10);
        chk("wr_addr", addr, 24'h2);
        chk("wr_value", value, 32'hDEADBEEF);
        chk("wr_instr", instr, 8'h01);
        cyc(1);
        chk("wr_cmd_valid_t2", cmd_valid, 0);
        chk("wr_core_sel_t2", core_sel, 2'b10);
        cyc(1);
        chk("wr_core_sel_t3", core_sel, 2'b10);
        rv = 2'b10;
        cyc(1);
        rv = 0;
        chk("wr_core_sel_done", core_sel, 0);
        chk("wr_tx_status", tx, 8'hA5);

        // READ core 0 returning 0x12345678, ack at t+2
        result[31:0] = 32'h12345678;
        send_frame({8'h02, 24'h000005, 32'h0}, 0);
        chk_tx("wr_resp", {8'hA5, 24'h0, 32'h0BADF00D});
        chk("rd_cmd_valid", cmd_valid, 1);
        chk("rd_core_sel", core_sel, 2'b01);
        chk("rd_addr", addr, 24'h5);
        cyc(1);
        rv = 2'b01;
        cyc(1);
        rv = 0;
        chk("rd_core_sel_done", core_sel, 0);

        // NOP shows the read response
        send_frame({8'h00, 24'h0, 32'h0}, 0);
        chk_tx("rd_resp", {8'hA5, 24'h0, 32'h12345678});
        chk("nop_cmd_valid", cmd_valid, 0);
        cyc(1);
        chk("nop_tx_t2", tx, 8'hA5);

        // Bad address
        send_frame({8'h02, 24'h000020, 32'h0}, 0);
        chk_tx("nop_resp", {8'hA5, 56'h0});
        chk("badaddr_cmd_valid", cmd_valid, 0);
        chk("badaddr_core_sel", core_sel, 0);
        cyc(1);
        chk("badaddr_tx", tx, 8'hE1);

        // Bad opcode
        send_frame({8'h7F, 24'h0, 32'h0}, 0);
        chk_tx("badaddr_resp", {8'hE1, 56'h0});
        chk("badop_cmd_valid", cmd_valid, 0);
        cyc(1);
        chk("badop_tx", tx, 8'hE2);

        // Abort after 3 bytes, then a clean NOP frame
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1; rx_byte = 8'h01; cyc(1);
        end
        rx_valid = 0; abort = 1; cyc(1); abort = 0;
        chk("abort_tx", tx, 8'hE2);
        send_frame({8'h00, 24'h0, 32'h0}, 0);
        chk_tx("badop_resp", {8'hE2, 56'h0});
        cyc(1);
        chk("abort_nop_tx", tx, 8'hA5);

        // STREAM from core 1
        stream[63:32] = 32'hCAFEF00D;
        send_frame({8'h03, 24'h000015, 32'h0}, 0);
        chk("stream_cmd_valid", cmd_valid, 0);
        chk("stream_core_sel", core_sel, 0);
        cyc(1);
        chk("stream_tx", tx, 8'hA5);

        // Abort coincident with a strobe discards that byte
        rx_valid = 1; rx_byte = 8'h00; cyc(1);
        rx_valid = 0; cyc(1);
        rx_valid = 1; rx_byte = 8'hFF; abort = 1; cyc(1);
        rx_valid = 0; abort = 0;
        chk("abort_strobe_tx", tx, 8'hA5);
        send_frame({8'h00, 24'h0, 32'h0}, 1);
        chk_tx("stream_resp", {8'hA5, 24'h0, 32'hCAFEF00D});
        cyc(1);
        chk("abort_strobe_nop_tx", tx, 8'hA5);

        // Timeout: E3 at exactly t+10, later ack ignored
        send_frame({8'h02, 24'h000003, 32'h0}, 0);
        chk("tmo_core_sel_t1", core_sel, 2'b01);
        cyc(8);
        chk("tmo_core_sel_t9", core_sel, 2'b01);
        cyc(1);
        chk("tmo_core_sel_t10", core_sel, 0);
        chk("tmo_tx_t10", tx, 8'hE3);
        result[31:0] = 32'h55555555;
        rv = 2'b01; cyc(1); rv = 0;
        chk("tmo_spurious_core_sel", core_sel, 0);
        send_frame({8'h00, 24'h0, 32'h0}, 0);
        chk_tx("tmo_resp", {8'hE3, 56'h0});
        cyc(1);

        // Busy: second frame completes during WAIT, dropped, E4 overrides result
        send_frame({8'h02, 24'h000001, 32'h0}, 0);
        chk("busy_cmd_valid", cmd_valid, 1);
        send_frame({8'h01, 24'h000011, 32'h11223344}, 1);
        chk("busy_drop_cmd_valid", cmd_valid, 0);
        chk("busy_core_sel", core_sel, 2'b01);
        chk("busy_instr_stable", instr, 8'h02);
        result[31:0] = 32'h99999999;
        rv = 2'b01; cyc(1); rv = 0;
        chk("busy_core_sel_done", core_sel, 0);
        chk("busy_tx", tx, 8'hE4);
        send_frame({8'h00, 24'h0, 32'h0}, 0);
        chk_tx("busy_resp", {8'hE4, 56'h0});
        cyc(1);

        // Reset mid-WAIT
        send_frame({8'h01, 24'h000010, 32'hA5A5A5A5}, 0);
        cyc(1);
        rst_n = 0;
        #1;
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_core_sel", core_sel, 0);
        chk("midrst_tx", tx, 0);
        chk("midrst_buses", {instr, addr, value}, 0);
        @(negedge clk);
        rst_n = 1;
        cyc(1);
        result[63:32] = 32'h77777777;
        rv = 2'b10; cyc(1); rv = 0;
        chk("midrst_late_ack_core_sel", core_sel, 0);
        chk("midrst_late_ack_tx", tx, 0);
        send_frame({8'h00, 24'h0, 32'h0}, 0);
        chk_tx("midrst_resp", 64'h0);
        cyc(1);
        chk("midrst_nop_tx", tx, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_command_router.md
# spi_command_router

Parametrised command router between the SPI byte interface and a bank of `NUM_CORES` core interfaces. It assembles 8-byte command frames from the received SPI bytes and decodes the address to one core. It issues the command with a valid/acknowledge handshake and a timeout, then serialises a status and result response back out through the SPI transmit byte. It replaces the single-core instruction handler in multi-core builds: all cores share the instruction, address and value buses, and results are returned per core rather than over a shared result bus.

## Interface
- `NUM_CORES`, 2: number of attached cores, 1..16.
- `CORE_SPAN`, 16: addresses owned per core; must be a power of two.
- `TIMEOUT`, 255: maximum WAIT cycles for an acknowledge; 8-bit counter.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: asynchronous reset, active-low.
- `spi_rx_valid_i` in 1: one-cycle strobe, `spi_rx_byte_i` valid.
- `spi_rx_byte_i` in 8: received byte.
- `frame_abort_i` in 1: chip select deasserted (already synchronised); resets the byte counter.
- `spi_tx_byte_o` out 8: byte the SPI interface transmits next.
- `cmd_valid_o` out 1: one-cycle command strobe.
- `core_sel_o` out NUM_CORES: one-hot target; held from ISSUE until the end of WAIT.
- `instruction_o` out 8, `address_o` out 24 (core-local), `value_o` out 32: command buses; stable while `core_sel_o` is non-zero.
- `result_i` in NUM_CORES*32: per-core result; core k at bits [32k+31:32k].
- `result_valid_i` in NUM_CORES: per-core acknowledge, with result valid.
- `stream_i` in NUM_CORES*32: per-core free-running stream value.

## Operation
- Frame layout: byte 0 is the opcode; bytes 1-3 are the address, MSB first; bytes 4-7 are the value, MSB first. `idx` (0..7) counts accepted bytes and wraps 7->0.
- Opcodes:
  - 0x00 NOP.
  - 0x01 WRITE.
  - 0x02 READ.
  - 0x03 STREAM.
  - Any other opcode is rejected with status 0xE2.
- Decode: k = addr / CORE_SPAN; local = addr mod CORE_SPAN. If addr >= NUM_CORES*CORE_SPAN, status is 0xE1 and nothing is issued.
- FSM states:
  - COLLECT (reset state): accepts bytes. Byte 7 moves to ISSUE.
  - ISSUE (1 cycle):
    - NOP: response {0xA5, 0}.
    - Bad opcode or bad address: response {err, 0}.
    - STREAM: captures `stream_i[k]`, response {0xA5, stream}.
    - In all of the above cases the FSM returns to COLLECT.
    - WRITE/READ: asserts `cmd_valid_o` and moves to WAIT.
  - WAIT:
    - `result_valid_i[k]` gives response {0xA5, result_i[k]} and returns to COLLECT.
    - A wait counter reaching TIMEOUT gives response {0xE3, 0} and returns to COLLECT.
    - `result_valid_i` from non-selected cores is ignored.
- Response register: 64 bits = {status, 0x0000_00, data[31:0]}. Byte j is transmitted while frame byte j is received.
- `spi_tx_byte_o` = response byte[idx], registered. It updates the cycle after every rx strobe, abort or response load.
- Busy: bytes keep counting in WAIT. If byte 7 of a new frame arrives while in WAIT, that frame is dropped. The response becomes {0xE4, 0} when WAIT ends, overriding the result.
- `frame_abort_i`: idx <- 0 in any state. It does not cancel an outstanding WAIT. It has priority over a simultaneous `spi_rx_valid_i`, whose byte is discarded.

## Timing
- Reset values:
  - FSM = COLLECT, idx = 0.
  - Response = all zero; `spi_tx_byte_o` = 0x00.
  - `cmd_valid_o` = 0, `core_sel_o` = 0.
  - `instruction_o`, `address_o`, `value_o` = 0.
- Reset mid-WAIT aborts immediately. A late `result_valid_i` after reset is ignored.
- Byte 7 strobe at cycle t:
  - ISSUE at t+1; `cmd_valid_o` and `core_sel_o` are high at t+1.
  - WAIT begins at t+2.
  - Acknowledge at cycle w >= t+2: response loaded at w+1; `core_sel_o` = 0 at w+1.
- Acknowledge at t+1 (same cycle as `cmd_valid_o`) is not seen; cores acknowledge at t+2 or later.
- Timeout: no acknowledge through t+1+TIMEOUT gives status 0xE3 loaded at t+2+TIMEOUT.
- NOP, STREAM and error responses are loaded at t+2. `spi_tx_byte_o` shows the status at t+2 (idx = 0).
- Throughput: one command per frame. Minimum frame spacing is 1 cycle between strobes.

## Test plan
- WRITE to core 1, addr 0x000012 with CORE_SPAN=16, value 0xDEADBEEF; ack at t+3 -> `core_sel_o`=2'b10, `address_o`=0x2, `value_o`=0xDEADBEEF, one-cycle `cmd_valid_o`; next frame's tx bytes are A5 00 00 00 then the four result bytes.
- READ to core 0 returning 0x12345678 -> next frame's tx bytes are A5 00 00 00 12 34 56 78.
- READ of addr 0x000020 with NUM_CORES=2 -> no `cmd_valid_o`; tx bytes E1 then seven 0x00. Opcode 0x7F -> status E2.
- READ with no acknowledge, TIMEOUT=8 -> status E3 loaded exactly 10 cycles after the byte 7 strobe. A later spurious ack is ignored.
- `frame_abort_i` after 3 bytes, then a full NOP frame -> frame is accepted cleanly with status A5. Abort coincident with a strobe discards that byte.
- Second frame completes during WAIT -> that frame is not issued; status E4 on the following frame. Reset asserted mid-WAIT -> all outputs return to reset values at once.
